// File: rtl/icache_line_fetcher.sv
// Instruction fetcher with a set-associative, multi-word-line I-cache.
// Hits forward to the decoder in the same cycle; misses refill a whole line one word at a time.
module icache_line_fetcher #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_rollback,
  input  logic              in_icache_flush,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              in_result_taken,
  input  logic              in_rs_ok,
  input  logic              in_rob_ok,
  output logic              out_decoder_and_pc_ena,
  output logic              out_pc_reg_ena,
  output logic [ADDR_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_decoder_pc,
  output logic              out_branch_taken,
  output logic              out_mem_ena,
  output logic [ADDR_W-1:0] out_address,
  input  logic              in_mem_ready,
  input  logic [ADDR_W-1:0] in_mem_inst
);

  localparam int unsigned OFF     = $clog2(LINE_WORDS);
  localparam int unsigned SETS    = 1 << INDEX_BITS;
  localparam int unsigned LINE_SH = OFF + 2;
  localparam int unsigned TAG_SH  = LINE_SH + INDEX_BITS;
  localparam int unsigned TAG_W   = ADDR_W - TAG_SH;
  localparam int unsigned LINE_W  = ADDR_W - LINE_SH;
  localparam int unsigned WORD_W  = (OFF > 0) ? OFF : 1;
  localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

  state_e            state_q;
  logic [SETS-1:0]   valid_q [WAYS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [ADDR_W-1:0] data_q  [WAYS][SETS][LINE_WORDS];
  logic [LINE_W-1:0] line_q;
  logic [WAY_W-1:0]  victim_q;
  logic [WORD_W-1:0] cnt_q;
  logic              out_mem_ena_q;
  logic [ADDR_W-1:0] out_address_q;

  logic [WORD_W-1:0]     pc_word;
  logic [INDEX_BITS-1:0] pc_set;
  logic [TAG_W-1:0]      pc_tag;
  logic [LINE_W-1:0]     pc_line;
  logic [INDEX_BITS-1:0] fill_set;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic                  abort_c;
  logic                  last_c;
  logic                  mem_wr_c;
  logic                  fetch_ok_c;

  assign pc_word  = (OFF > 0) ? WORD_W'(in_pc >> 2) : '0;
  assign pc_set   = INDEX_BITS'(in_pc >> LINE_SH);
  assign pc_tag   = TAG_W'(in_pc >> TAG_SH);
  assign pc_line  = LINE_W'(in_pc >> LINE_SH);
  assign fill_set = line_q[INDEX_BITS-1:0];
  assign fill_tag = line_q[LINE_W-1:INDEX_BITS];

  // Tag lookup; at most one way can match since a line is only ever filled into one way.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[WAY_W'(w)][pc_set] && (tag_q[WAY_W'(w)][pc_set] == pc_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign abort_c    = in_rollback | in_icache_flush;
  assign last_c     = (cnt_q == WORD_W'(LINE_WORDS - 1));
  assign mem_wr_c   = (state_q == WAIT) & in_mem_ready & ~abort_c;
  assign fetch_ok_c = hit & ~in_rollback & in_rs_ok & in_rob_ok &
                      ((state_q == IDLE) | (pc_line != line_q));

  assign out_decoder_and_pc_ena = fetch_ok_c;
  assign out_pc_reg_ena         = fetch_ok_c;
  assign out_inst               = data_q[hit_way][pc_set][pc_word];
  assign out_decoder_pc         = in_pc;
  assign out_branch_taken       = in_result_taken;
  assign out_mem_ena            = out_mem_ena_q;
  assign out_address            = out_address_q;

  // Refill FSM, valid bits and replacement pointers; flush is applied last so it always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      out_mem_ena_q <= 1'b0;
      out_address_q <= '0;
      line_q        <= '0;
      victim_q      <= '0;
      cnt_q         <= '0;
      for (int unsigned w = 0; w < WAYS; w++) valid_q[WAY_W'(w)] <= '0;
      for (int unsigned s = 0; s < SETS; s++) rr_q[INDEX_BITS'(s)] <= '0;
    end else begin
      out_mem_ena_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ena && !hit && !abort_c) begin
            line_q                         <= pc_line;
            victim_q                       <= rr_q[pc_set];
            cnt_q                          <= '0;
            valid_q[rr_q[pc_set]][pc_set]  <= 1'b0;
            state_q                        <= REQ;
          end
        end
        REQ: begin
          if (abort_c) begin
            state_q <= IDLE;
          end else begin
            out_mem_ena_q <= 1'b1;
            out_address_q <= (ADDR_W'(line_q) << LINE_SH) + (ADDR_W'(cnt_q) << 2);
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (in_mem_ready) begin
            if (abort_c) begin
              state_q <= IDLE;
            end else if (last_c) begin
              valid_q[victim_q][fill_set] <= 1'b1;
              rr_q[fill_set]              <= (WAYS > 1) ? rr_q[fill_set] + 1'b1 : '0;
              state_q                     <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= REQ;
            end
          end else if (abort_c) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (in_mem_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (in_icache_flush) begin
        for (int unsigned w = 0; w < WAYS; w++) valid_q[WAY_W'(w)] <= '0;
        for (int unsigned s = 0; s < SETS; s++) rr_q[INDEX_BITS'(s)] <= '0;
      end
    end
  end

  // Data and tag storage carry no reset; valid bits guard every read.
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      data_q[victim_q][fill_set][cnt_q] <= in_mem_inst;
      if (last_c) tag_q[victim_q][fill_set] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Scoreboard bench for icache_line_fetcher: directed fetch sequences, a small memory responder,
// and a monitor that pops expected requests and hit results as the DUT presents them.
`timescale 1ns/1ps
module tb_icache_line_fetcher;

  localparam int MEM_LAT = 2;

  typedef struct {
    logic [31:0] pc;
    logic        ena;
    logic        taken;
    logic [31:0] inst;
  } probe_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        in_rollback = 1'b0;
  logic        in_icache_flush = 1'b0;
  logic [31:0] in_pc = '0;
  logic        in_result_taken = 1'b0;
  logic        in_rs_ok = 1'b1;
  logic        in_rob_ok = 1'b1;
  logic        out_decoder_and_pc_ena;
  logic        out_pc_reg_ena;
  logic [31:0] out_inst;
  logic [31:0] out_decoder_pc;
  logic        out_branch_taken;
  logic        out_mem_ena;
  logic [31:0] out_address;
  logic        in_mem_ready = 1'b0;
  logic [31:0] in_mem_inst = '0;

  int errors = 0;
  int checks = 0;
  logic probe_v = 1'b0;
  logic [31:0] exp_req_q[$];
  probe_t      exp_probe_q[$];

  icache_line_fetcher dut (
    .clk                    (clk),
    .rst                    (rst),
    .ena                    (ena),
    .in_rollback            (in_rollback),
    .in_icache_flush        (in_icache_flush),
    .in_pc                  (in_pc),
    .in_result_taken        (in_result_taken),
    .in_rs_ok               (in_rs_ok),
    .in_rob_ok              (in_rob_ok),
    .out_decoder_and_pc_ena (out_decoder_and_pc_ena),
    .out_pc_reg_ena         (out_pc_reg_ena),
    .out_inst               (out_inst),
    .out_decoder_pc         (out_decoder_pc),
    .out_branch_taken       (out_branch_taken),
    .out_mem_ena            (out_mem_ena),
    .out_address            (out_address),
    .in_mem_ready           (in_mem_ready),
    .in_mem_inst            (in_mem_inst)
  );

  always #5 clk = ~clk;

  // Memory contents: line 0x100 holds 0x11..0x44, everything else 0xC000_0000 | address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return 32'hC000_0000 | a;
  endfunction

  // Memory responder: one outstanding read, data returned MEM_LAT cycles after the request pulse.
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  initial begin
    forever begin
      @(posedge clk); #1;
      in_mem_ready = 1'b0;
      if (rst) begin
        mem_busy = 1'b0;
      end else begin
        if (mem_busy) begin
          if (mem_cnt == 0) begin
            in_mem_ready = 1'b1;
            in_mem_inst  = mem_word(mem_addr);
            mem_busy     = 1'b0;
          end else begin
            mem_cnt--;
          end
        end
        if (out_mem_ena) begin
          checks++;
          if (mem_busy) begin
            errors++;
            $display("FAIL outstanding: request %h while %h still pending", out_address, mem_addr);
          end
          mem_busy = 1'b1;
          mem_addr = out_address;
          mem_cnt  = MEM_LAT - 1;
        end
      end
    end
  end

  // Monitor: compares every request pulse and every probed fetch against the scoreboard.
  logic [31:0] mon_exp;
  probe_t      mon_p;
  always @(negedge clk) begin
    if (out_mem_ena) begin
      checks++;
      if (exp_req_q.size() == 0) begin
        errors++;
        $display("FAIL mem_req: unexpected request addr=%h", out_address);
      end else begin
        mon_exp = exp_req_q.pop_front();
        if (out_address !== mon_exp) begin
          errors++;
          $display("FAIL mem_req: addr got %h expected %h", out_address, mon_exp);
        end
      end
    end
    if (probe_v && exp_probe_q.size() > 0) begin
      mon_p = exp_probe_q.pop_front();
      checks++;
      if (out_decoder_and_pc_ena !== mon_p.ena || out_pc_reg_ena !== mon_p.ena) begin
        errors++;
        $display("FAIL fetch_ena pc=%h: got %b/%b expected %b", mon_p.pc,
                 out_decoder_and_pc_ena, out_pc_reg_ena, mon_p.ena);
      end
      checks++;
      if (out_decoder_pc !== mon_p.pc || out_branch_taken !== mon_p.taken) begin
        errors++;
        $display("FAIL passthru pc=%h: got pc %h taken %b expected pc %h taken %b", mon_p.pc,
                 out_decoder_pc, out_branch_taken, mon_p.pc, mon_p.taken);
      end
      if (mon_p.ena) begin
        checks++;
        if (out_inst !== mon_p.inst) begin
          errors++;
          $display("FAIL inst pc=%h: got %h expected %h", mon_p.pc, out_inst, mon_p.inst);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic probe(input logic [31:0] pc, input logic exp_ena, input logic [31:0] exp_inst);
    probe_t p;
    in_pc           = pc;
    in_result_taken = pc[3];
    p.pc    = pc;
    p.ena   = exp_ena;
    p.taken = pc[3];
    p.inst  = exp_inst;
    exp_probe_q.push_back(p);
    probe_v = 1'b1;
    step();
    probe_v = 1'b0;
  endtask

  // Refill a whole line and wait (bounded) until it hits.
  task automatic fill(input logic [31:0] base);
    int n;
    for (int w = 0; w < 4; w++) exp_req_q.push_back(base + 32'(4 * w));
    in_pc = base;
    ena   = 1'b1;
    step();
    n = 0;
    while (!out_decoder_and_pc_ena && n < 200) begin
      step();
      n++;
    end
    ena = 1'b0;
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL fill_timeout base=%h: no hit after %0d cycles, expected hit", base, n);
    end
  endtask

  task automatic wait_req(input logic [31:0] addr, input string name);
    int n;
    n = 0;
    while (!(out_mem_ena && out_address == addr) && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s: no request to %h, expected one", name, addr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    step(); step();
    checks++;
    if (out_mem_ena !== 1'b0 || out_address !== 32'h0 || out_decoder_and_pc_ena !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mem_ena=%b addr=%h dec_ena=%b expected 0/0/0",
               out_mem_ena, out_address, out_decoder_and_pc_ena);
    end
    rst = 1'b0;
    step();

    // Reset in the middle of a refill.
    exp_req_q.push_back(32'h300);
    in_pc = 32'h300;
    ena   = 1'b1;
    wait_req(32'h300, "reset_refill_req");
    ena = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (out_mem_ena !== 1'b0 || out_address !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_refill: mem_ena=%b addr=%h expected 0/00000000", out_mem_ena, out_address);
    end
    step(); step();
    rst = 1'b0;
    step();
    probe(32'h300, 1'b0, 32'h0);
    probe(32'h000, 1'b0, 32'h0);

    // Cold miss and hit on the refilled line.
    fill(32'h100);
    probe(32'h108, 1'b1, 32'h33);
    probe(32'h100, 1'b1, 32'h11);
    probe(32'h10C, 1'b1, 32'h44);

    // Backpressure and rollback gate the hit.
    in_rob_ok = 1'b0;
    probe(32'h104, 1'b0, 32'h0);
    in_rob_ok = 1'b1;
    probe(32'h104, 1'b1, 32'h22);
    in_rs_ok = 1'b0;
    probe(32'h104, 1'b0, 32'h0);
    in_rs_ok = 1'b1;
    in_rollback = 1'b1;
    probe(32'h104, 1'b0, 32'h0);
    in_rollback = 1'b0;

    // Same-set fills and round-robin eviction.
    fill(32'h000);
    fill(32'h400);
    fill(32'h800);
    probe(32'h400, 1'b1, 32'hC000_0400);
    probe(32'h80C, 1'b1, 32'hC000_080C);
    probe(32'h000, 1'b0, 32'h0);
    probe(32'h108, 1'b1, 32'h33);

    // Flush invalidates every line.
    in_icache_flush = 1'b1;
    step();
    in_icache_flush = 1'b0;
    probe(32'h400, 1'b0, 32'h0);
    probe(32'h800, 1'b0, 32'h0);
    probe(32'h100, 1'b0, 32'h0);

    // Rollback while waiting on word 1: drain without issuing, then restart at the line base.
    exp_req_q.push_back(32'h100);
    exp_req_q.push_back(32'h104);
    in_pc = 32'h100;
    ena   = 1'b1;
    wait_req(32'h104, "rollback_word1_req");
    in_rollback = 1'b1;
    ena         = 1'b0;
    step();
    in_rollback = 1'b0;
    repeat (6) step();
    probe(32'h100, 1'b0, 32'h0);
    fill(32'h100);
    probe(32'h100, 1'b1, 32'h11);
    probe(32'h10C, 1'b1, 32'h44);

    repeat (8) step();
    checks++;
    if (exp_req_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_reqs: %0d expected requests never issued, expected 0", exp_req_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
